// File: rtl/cell_next_state_if.sv
// -----------------------------------------------------------------------------
// cell_next_state_if
// Groups the request/result handshake and the field-memory read port of
// cell_next_state. Signal names are seen from the evaluator's side
// (i_ = into the evaluator, o_ = out of it).
//
//   i_start       request evaluation of the cell at i_cell_x/y_adr
//   i_cell_x_adr  column of the cell to evaluate
//   i_cell_y_adr  row of the cell to evaluate
//   o_rd_en       field-memory read strobe
//   o_rd_x_adr    column of the field-memory read
//   o_rd_y_adr    row of the field-memory read
//   i_rd_data     cell state, valid one cycle after its o_rd_en
//   o_busy        evaluation in progress
//   o_done        one-cycle pulse, results valid
//   o_nbr_cnt     count of live in-field neighbours
//   o_next_state  next-generation state of the evaluated cell
//
// modport master : requester / field-memory side
// modport slave  : evaluator side
// -----------------------------------------------------------------------------
interface cell_next_state_if #(
  parameter int X_ADR_SIZE = 2,
  parameter int Y_ADR_SIZE = 2
);
  logic                  i_start;
  logic [X_ADR_SIZE-1:0] i_cell_x_adr;
  logic [Y_ADR_SIZE-1:0] i_cell_y_adr;
  logic                  o_rd_en;
  logic [X_ADR_SIZE-1:0] o_rd_x_adr;
  logic [Y_ADR_SIZE-1:0] o_rd_y_adr;
  logic                  i_rd_data;
  logic                  o_busy;
  logic                  o_done;
  logic [3:0]            o_nbr_cnt;
  logic                  o_next_state;

  modport master (
    output i_start, i_cell_x_adr, i_cell_y_adr, i_rd_data,
    input  o_rd_en, o_rd_x_adr, o_rd_y_adr, o_busy, o_done,
           o_nbr_cnt, o_next_state
  );

  modport slave (
    input  i_start, i_cell_x_adr, i_cell_y_adr, i_rd_data,
    output o_rd_en, o_rd_x_adr, o_rd_y_adr, o_busy, o_done,
           o_nbr_cnt, o_next_state
  );
endinterface

// File: rtl/cell_next_state.sv
// -----------------------------------------------------------------------------
// cell_next_state
// Evaluates one cell of a Game-of-Life field held in an external 1-bit
// memory: reads the (up to) eight in-field neighbours and the cell itself,
// counts live neighbours and produces the next-generation state.
// Latency is fixed: every neighbour slot takes one read cycle whether or not
// it lies inside the field, so o_done always follows i_start by 11 cycles.
//
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    cell_next_state_if.slave (request, memory read port, results)
//
// Also contains:
//   defs              shared constants
//   get_nbrs_address  combinational neighbour address / in-field decoder
// -----------------------------------------------------------------------------
package defs;
  localparam int unsigned NEIGHBOURS_CNT = 8;
endpackage

// -----------------------------------------------------------------------------
// get_nbrs_address
// For cell (x,y) produces the eight neighbour addresses in the order
//   0:(x-1,y-1) 1:(x,y-1) 2:(x+1,y-1) 3:(x-1,y)
//   4:(x+1,y)   5:(x-1,y+1) 6:(x,y+1) 7:(x+1,y+1)
// and a relevance bit per neighbour that is 1 only when it lies in the field.
// Addresses of irrelevant neighbours wrap and must not be used.
//
// Ports:
//   i_x_adr, i_y_adr  cell address
//   o_nbrs_x_adr      neighbour columns
//   o_nbrs_y_adr      neighbour rows
//   o_nbrs_rlvnt      neighbour lies inside the field
// -----------------------------------------------------------------------------
module get_nbrs_address
  import defs::*;
#(
  parameter  int FIELD_W    = 4,
  parameter  int FIELD_H    = 3,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic [X_ADR_SIZE-1:0]     i_x_adr,
  input  logic [Y_ADR_SIZE-1:0]     i_y_adr,
  output logic [X_ADR_SIZE-1:0]     o_nbrs_x_adr [NEIGHBOURS_CNT],
  output logic [Y_ADR_SIZE-1:0]     o_nbrs_y_adr [NEIGHBOURS_CNT],
  output logic [NEIGHBOURS_CNT-1:0] o_nbrs_rlvnt
);

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  logic [X_ADR_SIZE-1:0] w_xm;
  logic [X_ADR_SIZE-1:0] w_xp;
  logic [Y_ADR_SIZE-1:0] w_ym;
  logic [Y_ADR_SIZE-1:0] w_yp;
  logic                  w_has_l;
  logic                  w_has_r;
  logic                  w_has_u;
  logic                  w_has_d;

  assign w_xm    = i_x_adr - X_ADR_SIZE'(1);
  assign w_xp    = i_x_adr + X_ADR_SIZE'(1);
  assign w_ym    = i_y_adr - Y_ADR_SIZE'(1);
  assign w_yp    = i_y_adr + Y_ADR_SIZE'(1);
  assign w_has_l = (i_x_adr != '0);
  assign w_has_r = (i_x_adr < X_LAST);
  assign w_has_u = (i_y_adr != '0);
  assign w_has_d = (i_y_adr < Y_LAST);

  always_comb begin
    o_nbrs_x_adr[0] = w_xm;    o_nbrs_y_adr[0] = w_ym;
    o_nbrs_x_adr[1] = i_x_adr; o_nbrs_y_adr[1] = w_ym;
    o_nbrs_x_adr[2] = w_xp;    o_nbrs_y_adr[2] = w_ym;
    o_nbrs_x_adr[3] = w_xm;    o_nbrs_y_adr[3] = i_y_adr;
    o_nbrs_x_adr[4] = w_xp;    o_nbrs_y_adr[4] = i_y_adr;
    o_nbrs_x_adr[5] = w_xm;    o_nbrs_y_adr[5] = w_yp;
    o_nbrs_x_adr[6] = i_x_adr; o_nbrs_y_adr[6] = w_yp;
    o_nbrs_x_adr[7] = w_xp;    o_nbrs_y_adr[7] = w_yp;

    o_nbrs_rlvnt[0] = w_has_l & w_has_u;
    o_nbrs_rlvnt[1] = w_has_u;
    o_nbrs_rlvnt[2] = w_has_r & w_has_u;
    o_nbrs_rlvnt[3] = w_has_l;
    o_nbrs_rlvnt[4] = w_has_r;
    o_nbrs_rlvnt[5] = w_has_l & w_has_d;
    o_nbrs_rlvnt[6] = w_has_d;
    o_nbrs_rlvnt[7] = w_has_r & w_has_d;
  end

endmodule

// -----------------------------------------------------------------------------
// cell_next_state (top)
// -----------------------------------------------------------------------------
module cell_next_state
  import defs::*;
#(
  parameter int FIELD_W = 4,
  parameter int FIELD_H = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cell_next_state_if.slave  bus
);

  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WAIT,
    DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [X_ADR_SIZE-1:0]     r_x_adr;
  logic [Y_ADR_SIZE-1:0]     r_y_adr;
  logic [3:0]                r_idx;
  logic [3:0]                r_cnt;
  logic                      r_self;
  logic                      r_smp_vld;
  logic                      r_smp_self;
  logic [3:0]                r_nbr_cnt;
  logic                      r_next_state;

  logic [X_ADR_SIZE-1:0]     w_nbrs_x [NEIGHBOURS_CNT];
  logic [Y_ADR_SIZE-1:0]     w_nbrs_y [NEIGHBOURS_CNT];
  logic [NEIGHBOURS_CNT-1:0] w_nbrs_rlvnt;

  logic                      w_accept;
  logic                      w_busy;
  logic                      w_done;
  logic                      w_rd_en;
  logic [X_ADR_SIZE-1:0]     w_rd_x;
  logic [Y_ADR_SIZE-1:0]     w_rd_y;
  logic                      w_is_self;
  logic                      w_live_nbr;
  logic [3:0]                w_cnt_nxt;
  logic                      w_self_nxt;

  get_nbrs_address #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H)
  ) u_nbrs (
    .i_x_adr      (r_x_adr),
    .i_y_adr      (r_y_adr),
    .o_nbrs_x_adr (w_nbrs_x),
    .o_nbrs_y_adr (w_nbrs_y),
    .o_nbrs_rlvnt (w_nbrs_rlvnt)
  );

  // Index 8 (bit 3 set) is the cell itself; 0..7 select a neighbour.
  assign w_is_self = r_idx[3];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_x      = '0;
    w_rd_y      = '0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = RD;
        end
      end
      RD: begin
        w_busy = 1'b1;
        if (w_is_self) begin
          w_rd_en     = 1'b1;
          w_rd_x      = r_x_adr;
          w_rd_y      = r_y_adr;
          w_state_nxt = WAIT;
        end else begin
          w_rd_en = w_nbrs_rlvnt[r_idx[2:0]];
          w_rd_x  = w_nbrs_x[r_idx[2:0]];
          w_rd_y  = w_nbrs_y[r_idx[2:0]];
        end
      end
      WAIT: begin
        w_busy      = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        if (bus.i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = RD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read data belongs to the strobe of the previous cycle; r_smp_* remember
  // whether that strobe existed and whether it was the self read.
  assign w_live_nbr = r_smp_vld & ~r_smp_self & bus.i_rd_data;
  assign w_cnt_nxt  = r_cnt + {3'b000, w_live_nbr};
  assign w_self_nxt = (r_smp_vld & r_smp_self) ? bus.i_rd_data : r_self;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x_adr      <= '0;
      r_y_adr      <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_self       <= 1'b0;
      r_smp_vld    <= 1'b0;
      r_smp_self   <= 1'b0;
      r_nbr_cnt    <= '0;
      r_next_state <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x_adr    <= bus.i_cell_x_adr;
        r_y_adr    <= bus.i_cell_y_adr;
        r_idx      <= '0;
        r_cnt      <= '0;
        r_self     <= 1'b0;
        r_smp_vld  <= 1'b0;
        r_smp_self <= 1'b0;
      end else begin
        r_smp_vld  <= w_rd_en;
        r_smp_self <= w_is_self;
        r_cnt      <= w_cnt_nxt;
        r_self     <= w_self_nxt;
        if ((r_state == RD) && !w_is_self) begin
          r_idx <= r_idx + 4'd1;
        end
      end
      // The self sample arrives during WAIT, so results are formed from the
      // not-yet-registered count/self values at the WAIT->DONE edge.
      if (r_state == WAIT) begin
        r_nbr_cnt    <= w_cnt_nxt;
        r_next_state <= (w_cnt_nxt == 4'd3) | (w_self_nxt & (w_cnt_nxt == 4'd2));
      end
    end
  end

  assign bus.o_busy       = w_busy;
  assign bus.o_done       = w_done;
  assign bus.o_rd_en      = w_rd_en;
  assign bus.o_rd_x_adr   = w_rd_x;
  assign bus.o_rd_y_adr   = w_rd_y;
  assign bus.o_nbr_cnt    = r_nbr_cnt;
  assign bus.o_next_state = r_next_state;

endmodule

// File: tb/tb_cell_next_state.sv
// -----------------------------------------------------------------------------
// tb_cell_next_state
// Directed bench for cell_next_state on a 4x3 field. A behavioural field
// memory answers every read strobe one cycle later and drives random data
// in cycles without a pending read.
// -----------------------------------------------------------------------------
module tb_cell_next_state;

  logic clk;
  logic rst;

  cell_next_state_if #(.X_ADR_SIZE(2), .Y_ADR_SIZE(2)) bus ();

  cell_next_state #(.FIELD_W(4), .FIELD_H(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // field[y][x]
  logic field [3][4];

  // Field memory: data for a strobe seen in cycle n is driven in cycle n+1.
  logic       pend = 1'b0;
  logic [1:0] px   = '0;
  logic [1:0] py   = '0;
  always @(negedge clk) begin
    if (pend) bus.i_rd_data = field[py][px];
    else      bus.i_rd_data = 1'($urandom);
    pend = bus.o_rd_en;
    px   = bus.o_rd_x_adr;
    py   = bus.o_rd_y_adr;
  end

  // Observations per cycle (bit c = cycle c after the start edge).
  logic [31:0] obs_busy, obs_done, obs_rden, obs_next;
  logic [3:0]  obs_cnt [32];
  logic [63:0] obs_rdseq;
  int          obs_nrd;

  task automatic fill_field(input logic v);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        field[y][x] = v;
  endtask

  // Start at (x,y) in cycle 0, then run ncyc cycles. start_mask/rst_mask
  // bit c drives i_start/i_rst during cycle c. The address inputs are
  // scrambled whenever i_start is low to expose a missing address latch.
  task automatic run_eval(input logic [1:0] x, input logic [1:0] y,
                          input int unsigned ncyc,
                          input logic [31:0] start_mask,
                          input logic [31:0] rst_mask);
    @(negedge clk);
    bus.i_cell_x_adr = x;
    bus.i_cell_y_adr = y;
    bus.i_start      = 1'b1;
    obs_busy = '0; obs_done = '0; obs_rden = '0; obs_next = '0;
    obs_rdseq = '0; obs_nrd = 0;
    for (int unsigned c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      rst              = rst_mask[c];
      bus.i_start      = start_mask[c];
      bus.i_cell_x_adr = start_mask[c] ? x : ~x;
      bus.i_cell_y_adr = start_mask[c] ? y : 2'(y + 2'd1);
      #1;
      obs_busy[c] = bus.o_busy;
      obs_done[c] = bus.o_done;
      obs_rden[c] = bus.o_rd_en;
      obs_next[c] = bus.o_next_state;
      obs_cnt[c]  = bus.o_nbr_cnt;
      if (bus.o_rd_en === 1'b1) begin
        obs_rdseq = {obs_rdseq[59:0], bus.o_rd_x_adr, bus.o_rd_y_adr};
        obs_nrd++;
      end
    end
    bus.i_start = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_cell_x_adr = '0;
    bus.i_cell_y_adr = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.o_done); else n_pass++;
    n_checks++; if (bus.o_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", bus.o_rd_en); else n_pass++;
    n_checks++; if (bus.o_rd_x_adr !== 2'd0) $display("FAIL reset_rd_x got %0d want 0", bus.o_rd_x_adr); else n_pass++;
    n_checks++; if (bus.o_rd_y_adr !== 2'd0) $display("FAIL reset_rd_y got %0d want 0", bus.o_rd_y_adr); else n_pass++;
    n_checks++; if (bus.o_nbr_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", bus.o_nbr_cnt); else n_pass++;
    n_checks++; if (bus.o_next_state !== 1'b0) $display("FAIL reset_next got %b want 0", bus.o_next_state); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_corner();
    fill_field(1'b1);
    run_eval(2'd0, 2'd0, 13, 32'h0, 32'h0);
    n_checks++; if (obs_busy !== 32'h0000_07FE) $display("FAIL corner_busy got %h want 000007fe", obs_busy); else n_pass++;
    n_checks++; if (obs_done !== 32'h0000_0800) $display("FAIL corner_done got %h want 00000800", obs_done); else n_pass++;
    n_checks++; if (obs_rden !== 32'h0000_03A0) $display("FAIL corner_rden got %h want 000003a0", obs_rden); else n_pass++;
    n_checks++; if (obs_nrd != 4 || obs_rdseq[15:0] !== 16'h4150) $display("FAIL corner_addr got n=%0d seq=%h want n=4 seq=4150", obs_nrd, obs_rdseq[15:0]); else n_pass++;
    n_checks++; if (obs_cnt[11] !== 4'd3) $display("FAIL corner_cnt got %0d want 3", obs_cnt[11]); else n_pass++;
    n_checks++; if (obs_next[11] !== 1'b1) $display("FAIL corner_next got %b want 1", obs_next[11]); else n_pass++;
    n_checks++; if (obs_cnt[13] !== 4'd3 || obs_next[13] !== 1'b1) $display("FAIL corner_hold got cnt=%0d next=%b want cnt=3 next=1", obs_cnt[13], obs_next[13]); else n_pass++;
  endtask

  task automatic test_center();
    fill_field(1'b1);
    run_eval(2'd1, 2'd1, 13, 32'h0, 32'h0);
    n_checks++; if (obs_rden !== 32'h0000_03FE) $display("FAIL center_rden got %h want 000003fe", obs_rden); else n_pass++;
    n_checks++; if (obs_nrd != 9 || obs_rdseq[35:0] !== 36'h04819_26A5) $display("FAIL center_addr got n=%0d seq=%h want n=9 seq=0481926a5", obs_nrd, obs_rdseq[35:0]); else n_pass++;
    n_checks++; if (obs_cnt[11] !== 4'd8) $display("FAIL center_cnt got %0d want 8", obs_cnt[11]); else n_pass++;
    n_checks++; if (obs_next[11] !== 1'b0) $display("FAIL center_next got %b want 0", obs_next[11]); else n_pass++;
    n_checks++; if (obs_done !== 32'h0000_0800) $display("FAIL center_done got %h want 00000800", obs_done); else n_pass++;
  endtask

  task automatic test_edge();
    fill_field(1'b0);
    field[1][2] = 1'b1; field[1][3] = 1'b1; field[2][3] = 1'b1;
    run_eval(2'd3, 2'd2, 13, 32'h0, 32'h0);
    n_checks++; if (obs_rden !== 32'h0000_0216) $display("FAIL edge_rden got %h want 00000216", obs_rden); else n_pass++;
    n_checks++; if (obs_nrd != 4 || obs_rdseq[15:0] !== 16'h9DAE) $display("FAIL edge_addr got n=%0d seq=%h want n=4 seq=9dae", obs_nrd, obs_rdseq[15:0]); else n_pass++;
    n_checks++; if (obs_cnt[11] !== 4'd2 || obs_next[11] !== 1'b1) $display("FAIL edge_alive got cnt=%0d next=%b want cnt=2 next=1", obs_cnt[11], obs_next[11]); else n_pass++;
    field[2][3] = 1'b0;
    run_eval(2'd3, 2'd2, 13, 32'h0, 32'h0);
    n_checks++; if (obs_cnt[11] !== 4'd2 || obs_next[11] !== 1'b0) $display("FAIL edge_dead got cnt=%0d next=%b want cnt=2 next=0", obs_cnt[11], obs_next[11]); else n_pass++;
  endtask

  task automatic test_rules();
    // Birth: three neighbours, self dead.
    fill_field(1'b0);
    field[0][0] = 1'b1; field[0][1] = 1'b1; field[0][2] = 1'b1;
    run_eval(2'd1, 2'd1, 13, 32'h0, 32'h0);
    n_checks++; if (obs_cnt[11] !== 4'd3 || obs_next[11] !== 1'b1) $display("FAIL rule_birth got cnt=%0d next=%b want cnt=3 next=1", obs_cnt[11], obs_next[11]); else n_pass++;
    // Overcrowding: four neighbours, self alive.
    field[1][0] = 1'b1; field[1][1] = 1'b1;
    run_eval(2'd1, 2'd1, 13, 32'h0, 32'h0);
    n_checks++; if (obs_cnt[11] !== 4'd4 || obs_next[11] !== 1'b0) $display("FAIL rule_crowd got cnt=%0d next=%b want cnt=4 next=0", obs_cnt[11], obs_next[11]); else n_pass++;
    // Two neighbours, self dead: stays dead.
    fill_field(1'b0);
    field[0][0] = 1'b1; field[2][2] = 1'b1;
    run_eval(2'd1, 2'd1, 13, 32'h0, 32'h0);
    n_checks++; if (obs_cnt[11] !== 4'd2 || obs_next[11] !== 1'b0) $display("FAIL rule_two_dead got cnt=%0d next=%b want cnt=2 next=0", obs_cnt[11], obs_next[11]); else n_pass++;
  endtask

  task automatic test_start_ignored();
    fill_field(1'b0);
    field[1][2] = 1'b1; field[1][3] = 1'b1; field[2][3] = 1'b1;
    run_eval(2'd3, 2'd2, 13, 32'h0000_0408, 32'h0);
    n_checks++; if (obs_done !== 32'h0000_0800) $display("FAIL ignore_done got %h want 00000800", obs_done); else n_pass++;
    n_checks++; if (obs_busy !== 32'h0000_07FE) $display("FAIL ignore_busy got %h want 000007fe", obs_busy); else n_pass++;
    n_checks++; if (obs_cnt[13] !== 4'd2 || obs_next[13] !== 1'b1) $display("FAIL ignore_result got cnt=%0d next=%b want cnt=2 next=1", obs_cnt[13], obs_next[13]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    fill_field(1'b1);
    run_eval(2'd1, 2'd1, 13, 32'h0, 32'h0000_0060);
    n_checks++; if (obs_cnt[4] !== 4'd2 || obs_next[4] !== 1'b1) $display("FAIL rstmid_before got cnt=%0d next=%b want cnt=2 next=1", obs_cnt[4], obs_next[4]); else n_pass++;
    n_checks++; if (obs_cnt[5] !== 4'd0 || obs_next[5] !== 1'b0) $display("FAIL rstmid_clear got cnt=%0d next=%b want cnt=0 next=0", obs_cnt[5], obs_next[5]); else n_pass++;
    n_checks++; if (obs_busy !== 32'h0000_001E) $display("FAIL rstmid_busy got %h want 0000001e", obs_busy); else n_pass++;
    n_checks++; if (obs_rden !== 32'h0000_001E) $display("FAIL rstmid_rden got %h want 0000001e", obs_rden); else n_pass++;
    n_checks++; if (obs_done !== 32'h0) $display("FAIL rstmid_done got %h want 00000000", obs_done); else n_pass++;
    run_eval(2'd1, 2'd1, 13, 32'h0, 32'h0);
    n_checks++; if (obs_done !== 32'h0000_0800) $display("FAIL rstmid_after_done got %h want 00000800", obs_done); else n_pass++;
    n_checks++; if (obs_cnt[11] !== 4'd8 || obs_next[11] !== 1'b0) $display("FAIL rstmid_after_result got cnt=%0d next=%b want cnt=8 next=0", obs_cnt[11], obs_next[11]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    fill_field(1'b1);
    run_eval(2'd1, 2'd1, 24, 32'hFFFF_FFFF, 32'h0);
    n_checks++; if (obs_done !== 32'h0040_0800) $display("FAIL b2b_done got %h want 00400800", obs_done); else n_pass++;
    n_checks++; if (obs_busy !== 32'h01BF_F7FE) $display("FAIL b2b_busy got %h want 01bff7fe", obs_busy); else n_pass++;
    n_checks++; if (obs_rden !== 32'h019F_F3FE) $display("FAIL b2b_rden got %h want 019ff3fe", obs_rden); else n_pass++;
    n_checks++; if (obs_cnt[22] !== 4'd8 || obs_next[22] !== 1'b0) $display("FAIL b2b_result got cnt=%0d next=%b want cnt=8 next=0", obs_cnt[22], obs_next[22]); else n_pass++;
    // Abort the evaluation still running from the held start.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL b2b_abort_busy got %b want 0", bus.o_busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_corner();
    test_center();
    test_edge();
    test_rules();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
